hazard_unit: RTL and testbench

Pipeline hazard controller for the RV32I five-stage core; it drives the EX-stage operand forwarding selects and the IF/ID/EX stall and flush controls. It keeps its own shadow of the destination-register state of the instructions in EX, MEM and WB, fed from decode. From that shadow it:
- resolves RAW hazards by forwarding,
- inserts a one-cycle bubble on load-use,
- squashes wrong-path instructions on a taken branch or jump,
- freezes the pipeline while data memory is not ready.

---
 rtl/hazard_unit_pkg.sv | 21 ++
 rtl/hazard_stage_shadow.sv | 104 ++++++++++
 rtl/hazard_unit.sv | 176 +++++++++++++++++
 tb/tb_hazard_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller. These are the
// hazard-related types and constants that are also used by the execution
// unit and the decoder.
//   hazard_state_t : hazard FSM states (RUN, LU_STALL, MEM_WAIT)
//   FWD_*          : EX operand forwarding select encodings
//   NB_REG_ADDR    : architectural register-address width
package hazard_unit_pkg;

  localparam int NB_REG_ADDR = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hazard_state_t;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_WB     = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

endpackage

// File: rtl/hazard_stage_shadow.sv
// Shadow of the destination-register state of the instructions in EX, MEM
// and WB, fed from decode. Stages are _p0 (EX), _p1 (MEM), _p2 (WB).
//   clock, reset   : core clock, synchronous active-high reset
//   advance        : shift ID->EX->MEM->WB this cycle; low freezes everything
//   bubble         : load an empty slot into EX instead of the ID instruction
//   id_*           : decoded fields of the instruction in ID
//   ex_*/mem_*/wb_*: shadow contents used by the hazard logic
module hazard_stage_shadow #(
  parameter int NB_REG_ADDR = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   advance,
  input  logic                   bubble,
  input  logic                   id_valid,
  input  logic [NB_REG_ADDR-1:0] id_rs1,
  input  logic [NB_REG_ADDR-1:0] id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [NB_REG_ADDR-1:0] id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  output logic                   ex_valid,
  output logic [NB_REG_ADDR-1:0] ex_rd,
  output logic                   ex_mem_read,
  output logic [NB_REG_ADDR-1:0] ex_rs1,
  output logic [NB_REG_ADDR-1:0] ex_rs2,
  output logic                   ex_uses_rs1,
  output logic                   ex_uses_rs2,
  output logic                   mem_valid,
  output logic [NB_REG_ADDR-1:0] mem_rd,
  output logic                   mem_reg_write,
  output logic                   wb_valid,
  output logic [NB_REG_ADDR-1:0] wb_rd,
  output logic                   wb_reg_write
);

  // A bubble or an empty ID slot enters EX with all control bits cleared,
  // so nothing downstream can match on stale register fields.
  logic load_ex;
  assign load_ex = id_valid & ~bubble;

  logic                   valid_p0, uses_rs1_p0, uses_rs2_p0, reg_write_p0, mem_read_p0;
  logic                   valid_p1, reg_write_p1;
  logic                   valid_p2, reg_write_p2;
  logic [NB_REG_ADDR-1:0] rd_p0, rs1_p0, rs2_p0, rd_p1, rd_p2;

  // Control bits: the only state that reset touches.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_p0     <= 1'b0;
      uses_rs1_p0  <= 1'b0;
      uses_rs2_p0  <= 1'b0;
      reg_write_p0 <= 1'b0;
      mem_read_p0  <= 1'b0;
      valid_p1     <= 1'b0;
      reg_write_p1 <= 1'b0;
      valid_p2     <= 1'b0;
      reg_write_p2 <= 1'b0;
    end else if (advance) begin
      // ID -> EX
      valid_p0     <= load_ex;
      uses_rs1_p0  <= load_ex & id_uses_rs1;
      uses_rs2_p0  <= load_ex & id_uses_rs2;
      reg_write_p0 <= load_ex & id_reg_write;
      mem_read_p0  <= load_ex & id_mem_read;
      // EX -> MEM
      valid_p1     <= valid_p0;
      reg_write_p1 <= reg_write_p0;
      // MEM -> WB
      valid_p2     <= valid_p1;
      reg_write_p2 <= reg_write_p1;
    end
  end

  // Register-address fields: qualified by the control bits above.
  always_ff @(posedge clock) begin
    if (advance) begin
      // ID -> EX
      rd_p0  <= id_rd;
      rs1_p0 <= id_rs1;
      rs2_p0 <= id_rs2;
      // EX -> MEM
      rd_p1  <= rd_p0;
      // MEM -> WB
      rd_p2  <= rd_p1;
    end
  end

  assign ex_valid      = valid_p0;
  assign ex_rd         = rd_p0;
  assign ex_mem_read   = mem_read_p0;
  assign ex_rs1        = rs1_p0;
  assign ex_rs2        = rs2_p0;
  assign ex_uses_rs1   = uses_rs1_p0;
  assign ex_uses_rs2   = uses_rs2_p0;
  assign mem_valid     = valid_p1;
  assign mem_rd        = rd_p1;
  assign mem_reg_write = reg_write_p1;
  assign wb_valid      = valid_p2;
  assign wb_rd         = rd_p2;
  assign wb_reg_write  = reg_write_p2;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the RV32I five-stage core. Drives the EX
// operand forwarding selects and the IF/ID/EX stall and flush controls from
// its own EX/MEM/WB destination-register shadow.
//   i_clock, i_reset          : core clock, synchronous active-high reset
//   i_id_*                    : decoded fields of the instruction in ID
//   i_ex_branch_taken         : EX instruction redirects the PC this cycle
//   i_mem_ready               : data memory completes this cycle (0 = wait)
//   o_forward_rs1/rs2         : EX operand select (FWD_EX_MEM/FWD_WB/FWD_NONE)
//   o_stall_if/id/ex          : hold PC / IF/ID / ID/EX,EX/MEM,MEM/WB
//   o_bubble_ex, o_flush_id   : load NOP into ID/EX / squash IF/ID
//   o_stall_cycles            : saturating count of cycles with o_stall_if
//   o_flush_count             : saturating count of cycles with o_flush_id
module hazard_unit #(
  parameter int NB_REG_ADDR = 5,
  parameter int NB_COUNT    = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_id_valid,
  input  logic [NB_REG_ADDR-1:0] i_id_rs1,
  input  logic [NB_REG_ADDR-1:0] i_id_rs2,
  input  logic                   i_id_uses_rs1,
  input  logic                   i_id_uses_rs2,
  input  logic [NB_REG_ADDR-1:0] i_id_rd,
  input  logic                   i_id_reg_write,
  input  logic                   i_id_mem_read,
  input  logic                   i_ex_branch_taken,
  input  logic                   i_mem_ready,
  output logic [1:0]             o_forward_rs1,
  output logic [1:0]             o_forward_rs2,
  output logic                   o_stall_if,
  output logic                   o_stall_id,
  output logic                   o_stall_ex,
  output logic                   o_bubble_ex,
  output logic                   o_flush_id,
  output logic [NB_COUNT-1:0]    o_stall_cycles,
  output logic [NB_COUNT-1:0]    o_flush_count
);

  import hazard_unit_pkg::*;

  function automatic logic [NB_COUNT-1:0] sat_inc(input logic [NB_COUNT-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

  logic                   ex_valid, ex_mem_read, ex_uses_rs1, ex_uses_rs2;
  logic [NB_REG_ADDR-1:0] ex_rd, ex_rs1, ex_rs2;
  logic                   mem_valid, mem_reg_write;
  logic [NB_REG_ADDR-1:0] mem_rd;
  logic                   wb_valid, wb_reg_write;
  logic [NB_REG_ADDR-1:0] wb_rd;

  logic stall_if, stall_id, stall_ex, bubble_ex, flush_id;

  hazard_stage_shadow #(
    .NB_REG_ADDR(NB_REG_ADDR)
  ) u_shadow (
    .clock        (i_clock),
    .reset        (i_reset),
    .advance      (i_mem_ready),
    .bubble       (bubble_ex | flush_id),
    .id_valid     (i_id_valid),
    .id_rs1       (i_id_rs1),
    .id_rs2       (i_id_rs2),
    .id_uses_rs1  (i_id_uses_rs1),
    .id_uses_rs2  (i_id_uses_rs2),
    .id_rd        (i_id_rd),
    .id_reg_write (i_id_reg_write),
    .id_mem_read  (i_id_mem_read),
    .ex_valid     (ex_valid),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_uses_rs1  (ex_uses_rs1),
    .ex_uses_rs2  (ex_uses_rs2),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_reg_write(mem_reg_write),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write)
  );

  // A stage is a forwarding source only if it really writes a non-x0 register.
  logic mem_writes, wb_writes;
  assign mem_writes = mem_valid & mem_reg_write & (mem_rd != '0);
  assign wb_writes  = wb_valid & wb_reg_write & (wb_rd != '0);

  logic mem_hit_rs1, mem_hit_rs2, wb_hit_rs1, wb_hit_rs2;
  assign mem_hit_rs1 = ex_uses_rs1 & mem_writes & (mem_rd == ex_rs1);
  assign mem_hit_rs2 = ex_uses_rs2 & mem_writes & (mem_rd == ex_rs2);
  assign wb_hit_rs1  = ex_uses_rs1 & wb_writes & (wb_rd == ex_rs1);
  assign wb_hit_rs2  = ex_uses_rs2 & wb_writes & (wb_rd == ex_rs2);

  // MEM holds the younger result, so it wins over WB.
  assign o_forward_rs1 = mem_hit_rs1 ? FWD_EX_MEM : (wb_hit_rs1 ? FWD_WB : FWD_NONE);
  assign o_forward_rs2 = mem_hit_rs2 ? FWD_EX_MEM : (wb_hit_rs2 ? FWD_WB : FWD_NONE);

  logic mem_wait, branch, load_use;
  assign mem_wait = ~i_mem_ready;
  assign branch   = i_ex_branch_taken;
  assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) & i_id_valid &
                    ((i_id_uses_rs1 & (i_id_rs1 == ex_rd)) |
                     (i_id_uses_rs2 & (i_id_rs2 == ex_rd)));

  // FSM: tracks which hazard the pipeline is in. Outputs do not depend on it.
  hazard_state_t state, state_next;

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= RUN;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (mem_wait)                state_next = MEM_WAIT;
        else if (load_use && !branch) state_next = LU_STALL;
      end
      LU_STALL: begin
        // The bubble is now in EX, so the load has moved on to MEM.
        state_next = mem_wait ? MEM_WAIT : RUN;
      end
      MEM_WAIT: begin
        if (!mem_wait) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Priority: memory wait freezes everything, then a taken branch squashes
  // the ID instruction (which makes any load-use on it moot), then load-use.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (mem_wait) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
    end else if (branch) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (load_use) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  assign o_stall_if  = stall_if;
  assign o_stall_id  = stall_id;
  assign o_stall_ex  = stall_ex;
  assign o_bubble_ex = bubble_ex;
  assign o_flush_id  = flush_id;

  logic [NB_COUNT-1:0] stall_cycles, flush_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_if) stall_cycles <= sat_inc(stall_cycles);
      if (flush_id) flush_count  <= sat_inc(flush_count);
    end
  end

  assign o_stall_cycles = stall_cycles;
  assign o_flush_count  = flush_count;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  localparam int RW = 5;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          branch_taken, mem_ready;
  logic [1:0]    forward_rs1, forward_rs2;
  logic          stall_if, stall_id, stall_ex, bubble_ex, flush_id;
  logic [CW-1:0] stall_cycles, flush_count;

  always #5 clock = ~clock;

  hazard_unit #(.NB_REG_ADDR(RW), .NB_COUNT(CW)) dut (
    .i_clock          (clock),
    .i_reset          (reset),
    .i_id_valid       (id_valid),
    .i_id_rs1         (id_rs1),
    .i_id_rs2         (id_rs2),
    .i_id_uses_rs1    (id_uses_rs1),
    .i_id_uses_rs2    (id_uses_rs2),
    .i_id_rd          (id_rd),
    .i_id_reg_write   (id_reg_write),
    .i_id_mem_read    (id_mem_read),
    .i_ex_branch_taken(branch_taken),
    .i_mem_ready      (mem_ready),
    .o_forward_rs1    (forward_rs1),
    .o_forward_rs2    (forward_rs2),
    .o_stall_if       (stall_if),
    .o_stall_id       (stall_id),
    .o_stall_ex       (stall_ex),
    .o_bubble_ex      (bubble_ex),
    .o_flush_id       (flush_id),
    .o_stall_cycles   (stall_cycles),
    .o_flush_count    (flush_count)
  );

  // Reference model: the three in-flight instructions as plain records.
  typedef struct {
    bit valid; int rd; bit writes; bit load; int rs1; int rs2; bit reads1; bit reads2;
  } instr_t;

  instr_t m_ex, m_mem, m_wb;
  instr_t empty_slot = '{0, 0, 0, 0, 0, 0, 0, 0};
  int m_stalls, m_flushes;
  int e_f1, e_f2;
  bit e_sif, e_sid, e_sex, e_bub, e_fl;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Which older instruction supplies register r, if any: 2 = MEM, 1 = WB.
  function automatic int source_of(int r);
    if (r == 0) return 0;
    if (m_mem.valid && m_mem.writes && m_mem.rd == r) return 2;
    if (m_wb.valid && m_wb.writes && m_wb.rd == r) return 1;
    return 0;
  endfunction

  task automatic compute_expected();
    bit lu;
    e_f1 = (m_ex.valid && m_ex.reads1) ? source_of(m_ex.rs1) : 0;
    e_f2 = (m_ex.valid && m_ex.reads2) ? source_of(m_ex.rs2) : 0;
    lu = m_ex.valid && m_ex.load && m_ex.rd != 0 && id_valid &&
         ((id_uses_rs1 && int'(id_rs1) == m_ex.rd) || (id_uses_rs2 && int'(id_rs2) == m_ex.rd));
    {e_sif, e_sid, e_sex, e_bub, e_fl} = '0;
    if (!mem_ready) begin
      e_sif = 1; e_sid = 1; e_sex = 1;
    end else if (branch_taken) begin
      e_fl = 1; e_bub = 1;
    end else if (lu) begin
      e_sif = 1; e_sid = 1; e_bub = 1;
    end
  endtask

  task automatic pre(input string p);
    @(negedge clock);
    compute_expected();
    check({p, "_fwd1"}, forward_rs1, e_f1);
    check({p, "_fwd2"}, forward_rs2, e_f2);
    check({p, "_stall_if"}, stall_if, e_sif);
    check({p, "_stall_id"}, stall_id, e_sid);
    check({p, "_stall_ex"}, stall_ex, e_sex);
    check({p, "_bubble"}, bubble_ex, e_bub);
    check({p, "_flush"}, flush_id, e_fl);
    check({p, "_stall_cnt"}, stall_cycles, m_stalls);
    check({p, "_flush_cnt"}, flush_count, m_flushes);
  endtask

  task automatic post();
    instr_t id_i;
    @(posedge clock);
    if (reset) begin
      m_ex = empty_slot; m_mem = empty_slot; m_wb = empty_slot;
      m_stalls = 0; m_flushes = 0;
    end else begin
      if (e_sif) m_stalls = (m_stalls == CMAX) ? CMAX : m_stalls + 1;
      if (e_fl) m_flushes = (m_flushes == CMAX) ? CMAX : m_flushes + 1;
      if (mem_ready) begin
        id_i = '{id_valid, int'(id_rd), id_reg_write, id_mem_read,
                 int'(id_rs1), int'(id_rs2), id_uses_rs1, id_uses_rs2};
        m_wb = m_mem;
        m_mem = m_ex;
        m_ex = (e_bub || !id_valid) ? empty_slot : id_i;
      end
    end
    #1;
  endtask

  task automatic cycle(input string p);
    pre(p);
    post();
  endtask

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input bit mr);
    id_valid = v; id_rs1 = RW'(rs1); id_uses_rs1 = u1; id_rs2 = RW'(rs2); id_uses_rs2 = u2;
    id_rd = RW'(rd); id_reg_write = rw; id_mem_read = mr;
  endtask

  initial begin
    int s0;
    reset = 1; mem_ready = 1; branch_taken = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    m_ex = empty_slot; m_mem = empty_slot; m_wb = empty_slot;
    m_stalls = 0; m_flushes = 0;
    #1 reset = 0;

    pre("rst");
    check("rst_state", dut.state, RUN);
    post();

    // ALU chain on x5
    set_id(1, 0, 0, 0, 0, 5, 1, 0); cycle("alu1");
    set_id(1, 5, 1, 0, 0, 0, 0, 0); cycle("alu2");
    set_id(1, 5, 1, 0, 0, 0, 0, 0);
    pre("alu3"); check("alu_fwd_mem", forward_rs1, FWD_EX_MEM); post();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    pre("alu4"); check("alu_fwd_wb", forward_rs1, FWD_WB); post();

    // MEM and WB both write x7; then the same with x0
    set_id(1, 0, 0, 0, 0, 7, 1, 0); cycle("x7a");
    set_id(1, 0, 0, 0, 0, 7, 1, 0); cycle("x7b");
    set_id(1, 0, 0, 7, 1, 0, 0, 0); cycle("x7c");
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    pre("x7d"); check("prio_mem_over_wb", forward_rs2, FWD_EX_MEM); post();
    set_id(1, 0, 0, 0, 0, 0, 1, 0); cycle("x0a");
    set_id(1, 0, 0, 0, 0, 0, 1, 0); cycle("x0b");
    set_id(1, 0, 0, 0, 1, 0, 0, 0); cycle("x0c");
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    pre("x0d"); check("x0_no_fwd", forward_rs2, FWD_NONE); post();

    // Load-use on x3
    set_id(1, 0, 0, 0, 0, 3, 1, 1); cycle("lu1");
    set_id(1, 3, 1, 0, 0, 0, 0, 0);
    pre("lu2"); s0 = m_stalls;
    check("lu_stall_if", stall_if, 1); check("lu_bubble", bubble_ex, 1); post();
    pre("lu3");
    check("lu_one_cycle", stall_if, 0);
    check("lu_cnt_inc", stall_cycles, s0 + 1); post();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    pre("lu4"); check("lu_fwd_wb", forward_rs1, FWD_WB); post();

    // Taken branch coincident with load-use on x4
    set_id(1, 0, 0, 0, 0, 4, 1, 1); cycle("br1");
    set_id(1, 4, 1, 0, 0, 0, 0, 0); branch_taken = 1;
    pre("br2"); s0 = m_flushes;
    check("br_flush", flush_id, 1); check("br_bubble", bubble_ex, 1);
    check("br_no_stall", stall_if, 0); post();
    branch_taken = 0; set_id(0, 0, 0, 0, 0, 0, 0, 0);
    pre("br3"); check("br_cnt_inc", flush_count, s0 + 1); post();

    // Memory wait during a load-use on x9
    set_id(1, 0, 0, 0, 0, 9, 1, 1); cycle("mw1");
    set_id(1, 9, 1, 0, 0, 0, 0, 0); mem_ready = 0;
    pre("mw2"); s0 = m_stalls;
    check("mw_stall_ex", stall_ex, 1); check("mw_no_bubble", bubble_ex, 0); post();
    cycle("mw3"); cycle("mw4");
    mem_ready = 1;
    pre("mw5");
    check("mw_cnt_plus3", stall_cycles, s0 + 3);
    check("mw_bubble_after", bubble_ex, 1); post();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); cycle("mw6");

    // Reset during a memory wait
    mem_ready = 0; cycle("rw1");
    reset = 1; cycle("rw2");
    reset = 0; mem_ready = 1;
    pre("rw3");
    check("rw_state", dut.state, RUN);
    check("rw_stall_cnt", stall_cycles, 0); post();

    // Counter saturation
    mem_ready = 0;
    repeat (CMAX + 6) cycle("sat");
    mem_ready = 1;
    pre("sat_end"); check("sat_all_ones", stall_cycles, CMAX); post();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      mem_ready = ($urandom_range(0, 4) != 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      if (!e_sid)
        set_id($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 2) == 0);
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
